uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one UART transmitter (PISO) among NUM_REQ byte sources.
//  - Accepts one byte per valid/ready handshake and drives the transmitter's load/data inputs.
//  - Tracks each frame through the transmitter's active/done status.
//  - Flags a transmitter that never starts after a load.
//  - Sits between the byte producers (RX loopback, status reporters, etc.) and the PISO.
//  - Clocked by the same clock as the PISO (baud clock).
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  WIDTH     8   data width per requester; must equal the PISO WIDTH
//  TIMEOUT   16  cycles allowed after tx_load for tx_active to rise (>=2)
// PORTS
//  clk          in   1              clock (same clock as the PISO)
//  rst          in   1              synchronous, active-high reset
//  req_valid    in   NUM_REQ        per-requester byte available
//  req_data     in   NUM_REQ*WIDTH  requester i byte at [i*WIDTH +: WIDTH]
//  req_ready    out  NUM_REQ        one-hot acceptance strobe; byte taken at this clock edge
//  tx_load      out  1              one-cycle load pulse to the PISO
//  tx_data      out  WIDTH          registered byte presented to the PISO
//  tx_active    in   1              PISO frame in progress
//  tx_done      in   1              PISO frame complete pulse
//  grant_id     out  clog2(NUM_REQ) index of the requester owning the current frame
//  busy         out  1              high in every state except IDLE
//  timeout_err  out  1              one-cycle pulse: tx_active absent TIMEOUT cycles after load
// BEHAVIOUR
//  Reset (synchronous, rst=1 at posedge):
//   - state=IDLE; tx_load, tx_data, grant_id, busy, timeout_err, counter all 0.
//   - Last-grant pointer = NUM_REQ-1, so requester 0 wins first.
//   - rst mid-frame aborts the sequence at once; no req_ready or tx_load is issued that cycle.
//  FSM: IDLE -> LOAD -> WAIT_ACT -> WAIT_DONE -> IDLE.
//  IDLE:
//   - Arbitration runs only if |req_valid and tx_active=0.
//   - Winner = first valid index scanning ptr+1, ptr+2, ... modulo NUM_REQ.
//   - req_ready is combinational: req_ready[winner]=1 that cycle only; all other bits 0.
//   - At the edge: tx_data<=req_data[winner], grant_id<=winner, ptr<=winner, state->LOAD.
//   - Requesters hold valid and data stable until they see ready; a valid dropped before ready is legal (no grant).
//  LOAD:
//   - tx_load=1 for exactly this one cycle; counter cleared; next state WAIT_ACT.
//  WAIT_ACT:
//   - tx_active=1 -> WAIT_DONE.
//   - Else counter increments; when counter reaches TIMEOUT-1 without tx_active: timeout_err=1 for one cycle, state -> IDLE.
//   - tx_done while in WAIT_ACT (frame started and finished between samples) -> IDLE.
//  WAIT_DONE:
//   - tx_done=1 or tx_active=0 -> IDLE.
//   - tx_data and grant_id stay unchanged until the next grant.
//  Latency and throughput:
//   - req_ready edge -> tx_load high on the next cycle.
//   - After the frame ends, at least one IDLE cycle precedes the next req_ready.
//  Simultaneous requests: exactly one grant per frame; strict rotation, so no requester starves.
//  busy = (state != IDLE). No output is X after reset; tx_load and req_ready never assert in the same cycle.
// TESTING
//  1. Reset: rst high 2 cycles, req_valid=4'b1111 -> req_ready=0, tx_load=0, busy=0 throughout; first grant after release goes to 0.
//  2. Single request: req_valid=4'b0100, data[2]=8'hA5 -> req_ready=4'b0100 one cycle; tx_load pulse next cycle; tx_data=8'hA5, grant_id=2.
//  3. Round-robin: all four valid continuously, PISO model completes each frame -> grant order 0,1,2,3,0; exactly one tx_load per tx_done.
//  4. Timeout: tx_active tied 0 after a load -> timeout_err pulses exactly TIMEOUT cycles after tx_load; FSM back in IDLE, next request served.
//  5. Busy TX: tx_active=1 while in IDLE with req_valid=4'b0001 -> no req_ready until tx_active falls, then grant 0.
//  6. Mid-frame reset: rst in WAIT_DONE -> next cycle IDLE, all outputs 0, pointer reset (requester 0 wins next).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART PISO among NUM_REQ byte sources.
// Latency: req_ready edge -> tx_load the next cycle; one frame in flight at a time.
// Backpressure: req_ready is withheld while a frame is in flight or while the PISO reports tx_active.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_load,
  output logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACT  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  int               cand;

  // Rotating priority scan: first valid requester after the last grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // Frame sequencer; reset suppresses every strobe in the cycle it is asserted.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    tx_load     = 1'b0;
    timeout_err = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (win_found && !tx_active) begin
            req_ready[win_idx] = 1'b1;
            data_d             = req_data[int'(win_idx)*WIDTH +: WIDTH];
            grant_d            = win_idx;
            ptr_d              = win_idx;
            state_d            = ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_ACT;
        end
        ST_WAIT_ACT: begin
          if (tx_active) begin
            state_d = ST_WAIT_DONE;
          end else if (tx_done) begin
            // Short frame began and ended between two samples.
            state_d = ST_IDLE;
          end else if (cnt_q == CW'(TIMEOUT-1)) begin
            timeout_err = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done || !tx_active) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; pointer parks on the last index so 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NUM_REQ-1);
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, WIDTH=8, TIMEOUT=16).
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
// The PISO is played by hand through tx_active/tx_done.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx_load;
  logic [W-1:0]  tx_data;
  logic          tx_active;
  logic          tx_done;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] bytes [NR];

  uart_tx_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_load(tx_load), .tx_data(tx_data),
    .tx_active(tx_active), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pack();
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  // Called in the LOAD cycle: run one PISO frame and return in the following IDLE cycle.
  task automatic frame(input string tag);
    step();                       // WAIT_ACT
    tx_active = 1'b1;
    settle();
    chk({tag, "_wact_load"}, 32'(tx_load), 32'd0);
    chk({tag, "_wact_rdy"}, 32'(req_ready), 32'd0);
    step();                       // WAIT_DONE
    tx_done = 1'b1;
    settle();
    chk({tag, "_wdone_busy"}, 32'(busy), 32'd1);
    step();                       // back in IDLE
    tx_active = 1'b0;
    tx_done   = 1'b0;
    settle();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    pack();
    rst = 1'b1; req_valid = 4'b1111; tx_active = 1'b0; tx_done = 1'b0;

    // 1. Reset held two cycles with all requesters valid.
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_load", 32'(tx_load), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      chk("rst_txdata", 32'(tx_data), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
    end
    rst = 1'b0;
    settle();
    chk("first_grant_rdy", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    settle();
    chk("first_load", 32'(tx_load), 32'd1);
    chk("first_gid", 32'(grant_id), 32'd0);
    chk("first_data", 32'(tx_data), 32'h11);
    frame("f0");

    // 2. Single request on index 2.
    bytes[2] = 8'hA5;
    pack();
    req_valid = 4'b0100;
    settle();
    chk("single_rdy", 32'(req_ready), 32'b0100);
    chk("single_noload", 32'(tx_load), 32'd0);
    step();
    req_valid = 4'b0000;
    settle();
    chk("single_load", 32'(tx_load), 32'd1);
    chk("single_rdy_off", 32'(req_ready), 32'd0);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_gid", 32'(grant_id), 32'd2);
    frame("f1");

    // 3. Round-robin from a fresh reset, all valid continuously.
    bytes[2] = 8'h33;
    pack();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int e;
      e = n % NR;
      settle();
      chk("rr_rdy", 32'(req_ready), 32'(1 << e));
      step();
      settle();
      chk("rr_load", 32'(tx_load), 32'd1);
      chk("rr_gid", 32'(grant_id), 32'(e));
      chk("rr_data", 32'(tx_data), 32'(bytes[e]));
      frame("rr");
    end
    req_valid = 4'b0000;

    // 4. Timeout: ptr is 0, requester 1 wins, PISO never starts.
    req_valid = 4'b0010;
    settle();
    chk("to_rdy", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    settle();
    chk("to_load", 32'(tx_load), 32'd1);
    for (int k = 1; k < TO; k++) begin
      step();
      chk("to_early", 32'(timeout_err), 32'd0);
      chk("to_busy", 32'(busy), 32'd1);
    end
    step();
    chk("to_pulse", 32'(timeout_err), 32'd1);
    step();
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    req_valid = 4'b0100;
    settle();
    chk("to_next_rdy", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    settle();
    chk("to_next_gid", 32'(grant_id), 32'd2);
    frame("f2");

    // 5. PISO still active while idle: grant held off.
    tx_active = 1'b1;
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bsy_rdy", 32'(req_ready), 32'd0);
      chk("bsy_busy", 32'(busy), 32'd0);
      step();
    end
    tx_active = 1'b0;
    settle();
    chk("bsy_release_rdy", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    settle();
    chk("bsy_gid", 32'(grant_id), 32'd0);
    chk("bsy_load", 32'(tx_load), 32'd1);

    // 6. Reset in WAIT_DONE; pointer (now 0) must return to 3 so requester 0 wins again.
    step();                       // WAIT_ACT
    tx_active = 1'b1;
    step();                       // WAIT_DONE
    chk("mr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = 4'b1111;
    settle();
    chk("mr_rdy_during_rst", 32'(req_ready), 32'd0);
    chk("mr_load_during_rst", 32'(tx_load), 32'd0);
    step();
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_data0", 32'(tx_data), 32'd0);
    chk("mr_gid0", 32'(grant_id), 32'd0);
    chk("mr_terr0", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tx_active = 1'b0;
    settle();
    chk("mr_ptr_reset", 32'(req_ready), 32'b0001);
    step();
    settle();
    chk("mr_gid", 32'(grant_id), 32'd0);
    chk("mr_load", 32'(tx_load), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
